// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared constants for the run/step/halt sequencer and the ID-stage decoder.
package pipeline_run_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_RUN   = 3'b001;
  localparam logic [2:0] ST_STEP  = 3'b010;
  localparam logic [2:0] ST_DRAIN = 3'b011;
  localparam logic [2:0] ST_DONE  = 3'b100;

  localparam logic [1:0] CMD_PAUSE      = 2'b00;
  localparam logic [1:0] CMD_RUN        = 2'b01;
  localparam logic [1:0] CMD_STEP       = 2'b10;
  localparam logic [1:0] CMD_PIPE_RESET = 2'b11;

  // Opcode the ID decoder matches to raise i_halt_detected.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (i_clear) begin
      count_next = '0;
    end else if (i_enable && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign o_count = count_reg;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the five-stage pipeline: Moore FSM driving the
// global stall, PC freeze and pipe-reset pulse, plus an executed-cycle counter.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int NB_CYCLE     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt_detected,
  output logic                o_halt,
  output logic                o_pc_freeze,
  output logic                o_pipe_reset,
  output logic                o_program_done,
  output logic [2:0]          o_state,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [2:0]         state_reg;
  logic [2:0]         state_next;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_next;
  logic               pipe_reset_reg;
  logic               pipe_reset_next;
  logic               ready_state;
  logic               cmd_fire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      drain_cnt_reg  <= '0;
      pipe_reset_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drain_cnt_reg  <= drain_cnt_next;
      pipe_reset_reg <= pipe_reset_next;
    end
  end

  // While the reset pulse is out, ready drops so a back-to-back PIPE_RESET
  // waits one cycle instead of producing a two-cycle pulse.
  assign o_cmd_ready = ready_state & ~pipe_reset_reg;
  assign cmd_fire    = i_cmd_valid & o_cmd_ready;

  always_comb begin
    state_next      = state_reg;
    drain_cnt_next  = drain_cnt_reg;
    pipe_reset_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_RUN:        state_next = ST_RUN;
            CMD_STEP:       state_next = ST_STEP;
            CMD_PIPE_RESET: pipe_reset_next = 1'b1;
            default:        state_next = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 1);
        end else if (cmd_fire && (i_cmd == CMD_PAUSE)) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt_detected) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 1);
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        if (cmd_fire && (i_cmd == CMD_PIPE_RESET)) begin
          state_next      = ST_IDLE;
          pipe_reset_next = 1'b1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        drain_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    o_halt         = 1'b1;
    o_pc_freeze    = 1'b1;
    o_program_done = 1'b0;
    ready_state    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_state = 1'b1;
      end
      ST_RUN: begin
        o_halt      = 1'b0;
        o_pc_freeze = 1'b0;
        ready_state = 1'b1;
      end
      ST_STEP: begin
        o_halt      = 1'b0;
        o_pc_freeze = 1'b0;
      end
      ST_DRAIN: begin
        o_halt = 1'b0;
      end
      ST_DONE: begin
        o_program_done = 1'b1;
        ready_state    = 1'b1;
      end
      default: begin
        ready_state = 1'b0;
      end
    endcase
  end

  assign o_pipe_reset = pipe_reset_reg;
  assign o_state      = state_reg;

  sat_counter #(
    .WIDTH(NB_CYCLE)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (pipe_reset_next),
    .i_enable(~o_halt),
    .o_count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with a cycle-level reference model.
module tb_pipeline_run_ctrl;

  localparam logic [1:0] C_PAUSE = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_PRST  = 2'b11;

  logic        i_clk;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        i_halt_detected;
  logic        o_cmd_ready, o_halt, o_pc_freeze, o_pipe_reset, o_program_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;
  logic        n_cmd_ready, n_halt, n_pc_freeze, n_pipe_reset, n_program_done;
  logic [2:0]  n_state;
  logic [3:0]  n_cycle_count;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  pipeline_run_ctrl #(.DRAIN_CYCLES(3), .NB_CYCLE(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt_detected(i_halt_detected), .o_halt(o_halt),
    .o_pc_freeze(o_pc_freeze), .o_pipe_reset(o_pipe_reset), .o_program_done(o_program_done),
    .o_state(o_state), .o_cycle_count(o_cycle_count)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  pipeline_run_ctrl #(.DRAIN_CYCLES(3), .NB_CYCLE(4)) dut_narrow (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(n_cmd_ready), .i_halt_detected(i_halt_detected), .o_halt(n_halt),
    .o_pc_freeze(n_pc_freeze), .o_pipe_reset(n_pipe_reset), .o_program_done(n_program_done),
    .o_state(n_state), .o_cycle_count(n_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 step, 3 drain, 4 done.
  int     m_mode = 0;
  int     m_drain_left = 0;
  bit     m_pulse = 0;
  longint m_count = 0;

  function automatic bit m_ready();
    return ((m_mode == 0) || (m_mode == 1) || (m_mode == 4)) && !m_pulse;
  endfunction

  function automatic bit m_flowing();
    return (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
  endfunction

  always @(posedge i_clk) begin
    bit fire;
    bit pulse_now;
    if (i_reset) begin
      m_mode = 0; m_drain_left = 0; m_pulse = 0; m_count = 0;
    end else begin
      fire = i_cmd_valid && m_ready();
      pulse_now = 0;
      if (m_flowing()) m_count++;
      if (m_mode == 0) begin
        if (fire && i_cmd == C_RUN) m_mode = 1;
        else if (fire && i_cmd == C_STEP) m_mode = 2;
        else if (fire && i_cmd == C_PRST) begin pulse_now = 1; m_count = 0; end
      end else if (m_mode == 1 || m_mode == 2) begin
        if (i_halt_detected) begin m_mode = 3; m_drain_left = 3; end
        else if (m_mode == 2 || (fire && i_cmd == C_PAUSE)) m_mode = 0;
      end else if (m_mode == 3) begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 4;
      end else if (m_mode == 4) begin
        if (fire && i_cmd == C_PRST) begin pulse_now = 1; m_count = 0; m_mode = 0; end
      end
      m_pulse = pulse_now;
    end
  end

  always @(negedge i_clk) begin
    if (check_en) begin
      check("state", o_state, m_mode);
      check("halt", o_halt, !m_flowing());
      check("pc_freeze", o_pc_freeze, !(m_mode == 1 || m_mode == 2));
      check("cmd_ready", o_cmd_ready, m_ready());
      check("pipe_reset", o_pipe_reset, m_pulse);
      check("program_done", o_program_done, m_mode == 4);
      check("cycle_count", o_cycle_count, m_count & 64'hFFFF_FFFF);
      check("cycle_count_sat", n_cycle_count, (m_count > 15) ? 15 : m_count);
      check("narrow_state", n_state, m_mode);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // RUN accepted, HALT seen 10 cycles later, drain, done.
  task automatic run_to_halt(input string tag);
    send(C_RUN);
    check({tag, "_halt_low"}, o_halt, 0);
    repeat (9) tick();
    i_halt_detected = 1'b1;
    tick();
    i_halt_detected = 1'b0;
    check({tag, "_drain_state"}, o_state, 3);
    check({tag, "_drain_pcf"}, o_pc_freeze, 1);
    repeat (3) tick();
    check({tag, "_done_state"}, o_state, 4);
    check({tag, "_done_halt"}, o_halt, 1);
    check({tag, "_done_flag"}, o_program_done, 1);
    check({tag, "_count"}, o_cycle_count, 13);
    $display("txn %s: state=%0d count=%0d", tag, o_state, o_cycle_count);
  endtask

  initial begin
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = C_PAUSE; i_halt_detected = 1'b0;
    tick(); tick();
    check_en = 1;
    i_reset = 1'b0;
    repeat (5) tick();
    check("rst_state", o_state, 0);
    check("rst_halt", o_halt, 1);
    check("rst_pcf", o_pc_freeze, 1);
    check("rst_count", o_cycle_count, 0);
    check("rst_ready", o_cmd_ready, 1);
    $display("txn reset: state=%0d halt=%0d", o_state, o_halt);

    run_to_halt("run1");

    send(C_RUN);
    check("done_ignores_run", o_state, 4);
    send(C_PRST);
    check("prst_pulse", o_pipe_reset, 1);
    check("prst_count", o_cycle_count, 0);
    check("prst_done_clr", o_program_done, 0);
    check("prst_state", o_state, 0);
    tick();
    check("prst_pulse_end", o_pipe_reset, 0);
    $display("txn pipe_reset from done: state=%0d", o_state);

    // Back-to-back PIPE_RESET: second honoured one cycle later.
    i_cmd_valid = 1'b1; i_cmd = C_PRST;
    tick();
    check("b2b_pulse1", o_pipe_reset, 1);
    check("b2b_not_ready", o_cmd_ready, 0);
    tick();
    check("b2b_gap", o_pipe_reset, 0);
    tick();
    i_cmd_valid = 1'b0;
    check("b2b_pulse2", o_pipe_reset, 1);
    tick();
    $display("txn back-to-back pipe_reset");

    for (int k = 0; k < 3; k++) begin
      send(C_STEP);
      check("step_halt_low", o_halt, 0);
      check("step_not_ready", o_cmd_ready, 0);
      i_cmd_valid = 1'b1; i_cmd = C_RUN;
      tick();
      i_cmd_valid = 1'b0;
      check("step_back_idle", o_state, 0);
      repeat (2) tick();
      $display("txn step %0d: count=%0d", k, o_cycle_count);
    end
    check("step_count", o_cycle_count, 3);

    send(C_STEP);
    i_halt_detected = 1'b1;
    tick();
    i_halt_detected = 1'b0;
    check("step_halt_drain", o_state, 3);
    repeat (3) tick();
    check("step_halt_done", o_state, 4);
    check("step_halt_count", o_cycle_count, 7);
    $display("txn step into halt: state=%0d", o_state);
    send(C_PRST);
    tick();

    send(C_RUN);
    repeat (3) tick();
    i_cmd_valid = 1'b1; i_cmd = C_PAUSE; i_halt_detected = 1'b1;
    tick();
    i_cmd_valid = 1'b0; i_halt_detected = 1'b0;
    check("pause_vs_halt", o_state, 3);
    repeat (3) tick();
    check("pause_vs_halt_done", o_state, 4);
    $display("txn pause+halt: state=%0d", o_state);

    send(C_PRST);
    tick();
    send(C_RUN);
    repeat (2) tick();
    i_halt_detected = 1'b1;
    tick();
    i_halt_detected = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_drain_rst_state", o_state, 0);
    check("mid_drain_rst_halt", o_halt, 1);
    check("mid_drain_rst_count", o_cycle_count, 0);
    check("mid_drain_rst_done", o_program_done, 0);
    $display("txn reset mid-drain: state=%0d", o_state);
    run_to_halt("run2");

    send(C_PRST);
    tick();
    send(C_RUN);
    repeat (5) tick();
    send(C_STEP);
    check("run_drops_step", o_state, 1);
    repeat (14) tick();
    send(C_PAUSE);
    check("pause_state", o_state, 0);
    check("long_count", o_cycle_count, 21);
    check("long_count_sat", n_cycle_count, 15);
    $display("txn long run: count=%0d narrow=%0d", o_cycle_count, n_cycle_count);

    tick();
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Run/step/halt sequencer for the five-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Drives the common halt (stall) line that freezes every pipeline register, including the EX-stage outputs, plus a separate PC-freeze line.
- On detection of the HALT instruction in ID, freezes fetch and drains the remaining in-flight instructions through EX/MEM/WB, then stops.
- Commands arrive from the debug/UART unit over a valid/ready handshake; also counts executed cycles for the debug unit.

Parameters:
DRAIN_CYCLES, 3, cycles the pipeline keeps advancing after HALT is seen in ID (EX, MEM, WB).
NB_CYCLE, 32, width of the executed-cycle counter.

Ports:
i_clk  input  1  clock.
i_reset  input  1  synchronous, active-high reset.
i_cmd_valid  input  1  command present.
i_cmd  input  2  00 PAUSE, 01 RUN, 10 STEP, 11 PIPE_RESET.
o_cmd_ready  output  1  command accepted when i_cmd_valid & o_cmd_ready.
i_halt_detected  input  1  HALT opcode present in ID this cycle (qualified by ~o_halt).
o_halt  output  1  freezes all pipeline registers when 1.
o_pc_freeze  output  1  blocks PC update and IF/ID write when 1.
o_pipe_reset  output  1  one-cycle pulse clearing the pipeline registers and PC.
o_program_done  output  1  program finished and drained.
o_state  output  3  current state encoding.
o_cycle_count  output  NB_CYCLE  cycles with o_halt=0 since the last pipe reset.

Behaviour:
- Reset: state IDLE, o_halt=1, o_pc_freeze=1, o_pipe_reset=0, o_program_done=0, o_cycle_count=0, drain counter=0.
- Moore FSM. Outputs decode from the registered state, so a transition takes effect on the cycle after the accepting edge.
- States and o_state encoding: IDLE=000, RUN=001, STEP=010, DRAIN=011, DONE=100.
- IDLE:
  - Outputs: o_halt=1, o_pc_freeze=1, o_cmd_ready=1.
  - RUN -> RUN. STEP -> STEP.
  - PIPE_RESET -> o_pipe_reset=1 on the next cycle only, o_cycle_count cleared, stay IDLE.
  - PAUSE ignored.
- RUN:
  - Outputs: o_halt=0, o_pc_freeze=0, o_cmd_ready=1.
  - Only PAUSE is honoured (-> IDLE). Other commands are accepted and dropped.
  - i_halt_detected -> DRAIN, loading the drain counter with DRAIN_CYCLES-1.
  - i_halt_detected and PAUSE in the same cycle: DRAIN wins, PAUSE dropped.
- STEP:
  - Exactly one cycle with o_halt=0, o_pc_freeze=0, o_cmd_ready=0.
  - Next state is IDLE, or DRAIN if i_halt_detected in that cycle.
- DRAIN:
  - Outputs: o_halt=0, o_pc_freeze=1, o_cmd_ready=0. Lasts exactly DRAIN_CYCLES cycles.
  - Drain counter decrements each cycle; at 0 -> DONE. i_halt_detected is ignored.
  - Commands cannot be accepted because o_cmd_ready=0.
- DONE:
  - Outputs: o_halt=1, o_pc_freeze=1, o_program_done=1, o_cmd_ready=1.
  - Only PIPE_RESET is honoured: o_pipe_reset pulse, counter cleared, o_program_done cleared, -> IDLE. Other commands are dropped.
- o_cycle_count:
  - Increments in every cycle with o_halt=0.
  - Saturates at all-ones, no wrap.
  - Cleared only by i_reset or PIPE_RESET.
- o_pipe_reset is registered and never asserted in two consecutive cycles, even with back-to-back PIPE_RESET commands; the second command is honoured one cycle later.
- i_reset at any point (including mid-DRAIN or mid-STEP) forces the reset values on the next edge. An in-progress drain is abandoned.
- Unknown state encodings recover to IDLE.

Decomposition:
- Shared package holds:
  - state localparams (IDLE..DONE);
  - command encodings CMD_PAUSE/CMD_RUN/CMD_STEP/CMD_PIPE_RESET;
  - HALT opcode constant 6'b111111, shared with the ID decoder.
- One natural sub-module: sat_counter (saturating up-counter with synchronous clear and enable), used for o_cycle_count.
- The drain counter stays inline.

Test Plan:
- Reset then idle 5 cycles -> o_halt=1, o_pc_freeze=1, o_state=000, o_cycle_count=0, o_cmd_ready=1.
- RUN accepted at cycle t; i_halt_detected at t+10 -> o_halt=0 from t+1; o_pc_freeze=1 from t+11; DRAIN for 3 cycles; DONE (o_halt=1, o_program_done=1) at t+14; o_cycle_count=13.
- Three STEP commands, each separated by idle cycles -> exactly one o_halt=0 cycle per STEP; o_cycle_count=3; commands issued during STEP are not accepted (o_cmd_ready=0).
- RUN, then PAUSE and i_halt_detected in the same cycle -> state goes to DRAIN (011), not IDLE; DONE after 3 cycles.
- In DONE, send RUN -> ignored, still DONE. Send PIPE_RESET -> o_pipe_reset high exactly 1 cycle; o_cycle_count=0, o_program_done=0, state IDLE.
- i_reset asserted during the 2nd DRAIN cycle -> next cycle all outputs at reset values; a new RUN then behaves as in the second scenario.
